// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Bundles the instruction input, the datapath control strobes and the status
// outputs of the control sequencer.
//   master : the sequencer (reads ir_in/zero_flag, drives strobes and status)
//   slave  : the datapath side (drives ir_in/zero_flag, observes strobes)
// Signals:
//   ir_in        IR output, valid only while ir_read=1
//   zero_flag    ALU Z flag
//   pc_out/pc_inc/pc_load, mar_write, mem_read/mem_write, ir_write/ir_read,
//   imm_out, reg_sel/reg_out/reg_write, alu_a_write/alu_c_write/alu_op/alu_out
//                datapath control strobes
//   halted, illegal, instr_count   status
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 4,
  parameter int CNT_W     = 16
);
  logic [DATA_W-1:0]    ir_in;
  logic                 zero_flag;
  logic                 pc_out;
  logic                 pc_inc;
  logic                 pc_load;
  logic                 mar_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 ir_read;
  logic                 imm_out;
  logic [REG_SEL_W-1:0] reg_sel;
  logic                 reg_out;
  logic                 reg_write;
  logic                 alu_a_write;
  logic                 alu_c_write;
  logic                 alu_op;
  logic                 alu_out;
  logic                 halted;
  logic                 illegal;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  ir_in, zero_flag,
    output pc_out, pc_inc, pc_load, mar_write, mem_read, mem_write,
           ir_write, ir_read, imm_out, reg_sel, reg_out, reg_write,
           alu_a_write, alu_c_write, alu_op, alu_out,
           halted, illegal, instr_count
  );

  modport slave (
    output ir_in, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_write, mem_read, mem_write,
           ir_write, ir_read, imm_out, reg_sel, reg_out, reg_write,
           alu_a_write, alu_c_write, alu_op, alu_out,
           halted, illegal, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Fetch/decode/execute FSM for the 16-bit single-bus CPU.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; forces F0, clears fields and counter
//   bus    control_sequencer_if.master (instruction in, strobes and status out)
// The state, the latched instruction fields and the retired counter are
// registers. Strobes are a Moore decode of the registered state and fields,
// so each strobe is valid for the whole cycle of its state. Two values are
// only known during the cycle itself and are therefore decoded directly:
// illegal (from ir_in, which is valid only in DEC) and the JZ branch (from
// zero_flag in E0). While reset is high every strobe is held at 0.
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 4,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  reset,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_F0  = 3'd0,
    ST_F1  = 3'd1,
    ST_DEC = 3'd2,
    ST_E0  = 3'd3,
    ST_E1  = 3'd4,
    ST_E2  = 3'd5,
    ST_HLT = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [REG_SEL_W-1:0] rd_q, rd_d;
  logic [REG_SEL_W-1:0] rs_q, rs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 retire_s;

  logic [3:0]           ir_op_s;
  logic [REG_SEL_W-1:0] ir_rd_s;
  logic [REG_SEL_W-1:0] ir_rs_s;

  // The imm8 byte is driven onto the bus by the IR/immediate path itself;
  // the sequencer only needs op, rd and rs (rs is imm8[7:4]).
  assign ir_op_s = bus.ir_in[DATA_W-1 -: 4];
  assign ir_rd_s = bus.ir_in[DATA_W-5 -: REG_SEL_W];
  assign ir_rs_s = bus.ir_in[DATA_W-9 -: REG_SEL_W];

  // Opcodes 9..E are undefined and retire as NOP.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

  logic pc_out_s, pc_inc_s, pc_load_s, mar_write_s, mem_read_s, mem_write_s;
  logic ir_write_s, ir_read_s, imm_out_s, reg_out_s, reg_write_s;
  logic alu_a_write_s, alu_c_write_s, alu_op_s, alu_out_s, halted_s, illegal_s;
  logic [REG_SEL_W-1:0] reg_sel_s;

  // Next-state, field-latch and retire decode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    case (state_q)
      ST_F0:  state_d = ST_F1;
      ST_F1:  state_d = ST_DEC;
      ST_DEC: begin
        op_d = ir_op_s;
        rd_d = ir_rd_s;
        rs_d = ir_rs_s;
        case (ir_op_s)
          OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_JMP, OP_JZ:
                   state_d = ST_E0;
          OP_HALT: state_d = ST_HLT;
          default: state_d = ST_F0;
        endcase
      end
      ST_E0: begin
        case (op_q)
          OP_MOV, OP_ADD, OP_SUB, OP_LD, OP_ST: state_d = ST_E1;
          default:                              state_d = ST_F0;
        endcase
      end
      ST_E1: begin
        case (op_q)
          OP_ADD, OP_SUB: state_d = ST_E2;
          default:        state_d = ST_F0;
        endcase
      end
      ST_E2:  state_d = ST_F0;
      ST_HLT: state_d = ST_HLT;
      default: state_d = ST_F0;
    endcase
    // An instruction retires on the cycle that leaves its last state.
    retire_s = ((state_q == ST_DEC) || (state_q == ST_E0) ||
                (state_q == ST_E1) || (state_q == ST_E2)) &&
               ((state_d == ST_F0) || (state_d == ST_HLT));
    if (retire_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM state, latched fields and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_F0;
      op_q    <= 4'h0;
      rd_q    <= {REG_SEL_W{1'b0}};
      rs_q    <= {REG_SEL_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe decode from the registered state and fields.
  always_comb begin
    pc_out_s      = 1'b0;
    pc_inc_s      = 1'b0;
    pc_load_s     = 1'b0;
    mar_write_s   = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    ir_read_s     = 1'b0;
    imm_out_s     = 1'b0;
    reg_sel_s     = {REG_SEL_W{1'b0}};
    reg_out_s     = 1'b0;
    reg_write_s   = 1'b0;
    alu_a_write_s = 1'b0;
    alu_c_write_s = 1'b0;
    alu_op_s      = 1'b0;
    alu_out_s     = 1'b0;
    halted_s      = 1'b0;
    illegal_s     = 1'b0;
    if (reset) begin
      halted_s = 1'b0;
    end else begin
      case (state_q)
        ST_F0: begin
          pc_out_s    = 1'b1;
          mar_write_s = 1'b1;
        end
        ST_F1: begin
          mem_read_s = 1'b1;
          ir_write_s = 1'b1;
          pc_inc_s   = 1'b1;
        end
        ST_DEC: begin
          ir_read_s = 1'b1;
          illegal_s = is_illegal(ir_op_s);
        end
        ST_E0: begin
          case (op_q)
            OP_LDI: begin
              imm_out_s = 1'b1; reg_sel_s = rd_q; reg_write_s = 1'b1;
            end
            OP_MOV: begin
              reg_sel_s = rs_q; reg_out_s = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              reg_sel_s = rd_q; reg_out_s = 1'b1; alu_a_write_s = 1'b1;
            end
            OP_LD: begin
              reg_sel_s = rs_q; reg_out_s = 1'b1; mar_write_s = 1'b1;
            end
            OP_ST: begin
              reg_sel_s = rd_q; reg_out_s = 1'b1; mar_write_s = 1'b1;
            end
            OP_JMP: begin
              imm_out_s = 1'b1; pc_load_s = 1'b1;
            end
            OP_JZ: begin
              // Z cannot change between the last ADD/SUB and this cycle.
              if (bus.zero_flag) begin
                imm_out_s = 1'b1; pc_load_s = 1'b1;
              end else begin
                pc_load_s = 1'b0;
              end
            end
            default: pc_load_s = 1'b0;
          endcase
        end
        ST_E1: begin
          case (op_q)
            OP_MOV: begin
              // Bus value from E0 is held by the RF output latch.
              reg_sel_s = rd_q; reg_write_s = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              reg_sel_s = rs_q; reg_out_s = 1'b1; alu_c_write_s = 1'b1;
              alu_op_s = (op_q == OP_SUB);
            end
            OP_LD: begin
              mem_read_s = 1'b1; reg_sel_s = rd_q; reg_write_s = 1'b1;
            end
            OP_ST: begin
              reg_sel_s = rs_q; reg_out_s = 1'b1; mem_write_s = 1'b1;
            end
            default: reg_write_s = 1'b0;
          endcase
        end
        ST_E2: begin
          alu_out_s = 1'b1; reg_sel_s = rd_q; reg_write_s = 1'b1;
        end
        ST_HLT:  halted_s = 1'b1;
        default: halted_s = 1'b0;
      endcase
    end
  end

  assign bus.pc_out      = pc_out_s;
  assign bus.pc_inc      = pc_inc_s;
  assign bus.pc_load     = pc_load_s;
  assign bus.mar_write   = mar_write_s;
  assign bus.mem_read    = mem_read_s;
  assign bus.mem_write   = mem_write_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.ir_read     = ir_read_s;
  assign bus.imm_out     = imm_out_s;
  assign bus.reg_sel     = reg_sel_s;
  assign bus.reg_out     = reg_out_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.alu_a_write = alu_a_write_s;
  assign bus.alu_c_write = alu_c_write_s;
  assign bus.alu_op      = alu_op_s;
  assign bus.alu_out     = alu_out_s;
  assign bus.halted      = halted_s;
  assign bus.illegal     = illegal_s;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed and random instruction streams for control_sequencer. Expected
// per-cycle strobe vectors come from the instruction table (one list of
// cycles per opcode); the retired count is tracked as a plain integer.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 4;
  localparam int CNT_W     = 12;

  // Bit positions in the observed strobe vector.
  localparam int B_PC_OUT = 20, B_PC_INC = 19, B_PC_LOAD = 18, B_MAR_W = 17;
  localparam int B_MEM_R = 16, B_MEM_W = 15, B_IR_W = 14, B_IR_R = 13;
  localparam int B_IMM = 12, B_REG_OUT = 7, B_REG_W = 6, B_ALU_A = 5;
  localparam int B_ALU_C = 4, B_ALU_OP = 3, B_ALU_OUT = 2, B_HALT = 1;
  localparam int B_ILL = 0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   model_cnt;
  int   cycles;
  logic [20:0] exp_q[$];
  logic [20:0] obs;

  control_sequencer_if #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .CNT_W(CNT_W)) bus ();

  control_sequencer #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_write, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.ir_read, bus.imm_out, bus.reg_sel,
                bus.reg_out, bus.reg_write, bus.alu_a_write, bus.alu_c_write,
                bus.alu_op, bus.alu_out, bus.halted, bus.illegal};

  function automatic logic [20:0] v(input int b);
    logic [20:0] r;
    r = 21'd0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [20:0] sel(input logic [3:0] r);
    return {9'd0, r, 8'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected strobe vectors for each cycle of one instruction.
  task automatic build_expect(input logic [15:0] w, input logic zf);
    logic [3:0] op, rd, rs;
    op = w[15:12];
    rd = w[11:8];
    rs = w[7:4];
    exp_q = {};
    exp_q.push_back(v(B_PC_OUT) | v(B_MAR_W));
    exp_q.push_back(v(B_MEM_R) | v(B_IR_W) | v(B_PC_INC));
    exp_q.push_back(v(B_IR_R) | ((op >= 4'h9 && op <= 4'hE) ? v(B_ILL) : 21'd0));
    case (op)
      4'h1: exp_q.push_back(v(B_IMM) | sel(rd) | v(B_REG_W));
      4'h2: begin
        exp_q.push_back(sel(rs) | v(B_REG_OUT));
        exp_q.push_back(sel(rd) | v(B_REG_W));
      end
      4'h3, 4'h4: begin
        exp_q.push_back(sel(rd) | v(B_REG_OUT) | v(B_ALU_A));
        exp_q.push_back(sel(rs) | v(B_REG_OUT) | v(B_ALU_C) |
                        ((op == 4'h4) ? v(B_ALU_OP) : 21'd0));
        exp_q.push_back(v(B_ALU_OUT) | sel(rd) | v(B_REG_W));
      end
      4'h5: begin
        exp_q.push_back(sel(rs) | v(B_REG_OUT) | v(B_MAR_W));
        exp_q.push_back(v(B_MEM_R) | sel(rd) | v(B_REG_W));
      end
      4'h6: begin
        exp_q.push_back(sel(rd) | v(B_REG_OUT) | v(B_MAR_W));
        exp_q.push_back(sel(rs) | v(B_REG_OUT) | v(B_MEM_W));
      end
      4'h7: exp_q.push_back(v(B_IMM) | v(B_PC_LOAD));
      4'h8: exp_q.push_back(zf ? (v(B_IMM) | v(B_PC_LOAD)) : 21'd0);
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  // Runs an instruction starting in F0 (#1 after an edge). limit<0 runs it
  // to completion; otherwise stops on entry to cycle 'limit'.
  task automatic run_instr(input logic [15:0] w, input logic zf, input bit en,
                           input int limit);
    int n;
    int drivers;
    build_expect(w, zf);
    n = (limit < 0) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      bus.ir_in     = (i == 2) ? w : 16'($urandom);
      bus.zero_flag = (i == 3) ? zf : 1'($urandom);
      #1;
      if (en) begin
        chk($sformatf("strobes op%h c%0d", w[15:12], i), 32'(obs), 32'(exp_q[i]));
        drivers = int'(bus.pc_out) + int'(bus.mem_read) + int'(bus.imm_out) +
                  int'(bus.reg_out) + int'(bus.alu_out);
        chk("bus_onehot", 32'(drivers <= 1), 32'd1);
      end
      step();
    end
    if (limit < 0) begin
      model_cnt++;
      if (en) begin
        chk("instr_count", 32'(bus.instr_count), 32'(model_cnt % (1 << CNT_W)));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("reset_strobes", 32'(obs), 32'd0);
    chk("reset_count", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("after_reset_f0", 32'(obs), 32'(v(B_PC_OUT) | v(B_MAR_W)));
  endtask

  task automatic check_halted(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ir_in = 16'($urandom);
      bus.zero_flag = 1'($urandom);
      #1;
      chk("halted", 32'(obs), 32'(v(B_HALT)));
      chk("halt_count", 32'(bus.instr_count), 32'(model_cnt % (1 << CNT_W)));
      step();
    end
  endtask

  initial begin
    logic [15:0] w;
    checks = 0;
    errors = 0;
    model_cnt = 0;
    cycles = 0;
    reset = 1'b1;
    bus.ir_in = 16'h0000;
    bus.zero_flag = 1'b0;
    step();
    do_reset();

    // Directed instructions.
    run_instr(16'h1A42, 1'b0, 1'b1, -1);
    chk("ldi_count_one", 32'(bus.instr_count), 32'd1);
    run_instr(16'h3120, 1'b0, 1'b1, -1);
    run_instr(16'h4120, 1'b1, 1'b1, -1);
    run_instr(16'h8005, 1'b1, 1'b1, -1);
    run_instr(16'h8005, 1'b0, 1'b1, -1);
    run_instr(16'h7033, 1'b0, 1'b1, -1);
    run_instr(16'h2C5F, 1'b0, 1'b1, -1);
    run_instr(16'h5D90, 1'b0, 1'b1, -1);
    run_instr(16'h6E70, 1'b0, 1'b1, -1);
    run_instr(16'h0ABC, 1'b0, 1'b1, -1);
    run_instr(16'hB000, 1'b0, 1'b1, -1);
    run_instr(16'hF000, 1'b0, 1'b1, -1);
    check_halted(20);

    // Reset in the middle of ADD E1.
    do_reset();
    run_instr(16'h3120, 1'b0, 1'b1, 4);
    reset = 1'b1;
    #1;
    chk("reset_in_e1_gate", 32'(obs), 32'd0);
    step();
    chk("reset_e1_strobes", 32'(obs), 32'd0);
    chk("reset_e1_count", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("reset_e1_f0", 32'(obs), 32'(v(B_PC_OUT) | v(B_MAR_W)));

    // Random instruction stream.
    while (cycles < 10000) begin
      w = 16'($urandom);
      run_instr(w, 1'($urandom), 1'b1, -1);
      if (w[15:12] == 4'hF) begin
        check_halted(3);
        do_reset();
      end
    end

    // Counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      run_instr(16'h0000, 1'b0, 1'b0, -1);
    end
    chk("count_max", 32'(bus.instr_count), 32'h0000_0FFF);
    run_instr(16'h0000, 1'b0, 1'b1, -1);
    chk("count_wrap", 32'(bus.instr_count), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
